wb_slv_decoder: RTL and testbench
=================================

// Module: wb_slv_decoder
// PURPOSE
//  Single-master, NUM_SLV-slave Wishbone (B4 classic) decoder between the user-side
//  wb_host bridge and the user-project peripherals (pinmux, uart, spi, sram...).
//  Decodes the slave slot from address bits and forwards one transaction at a time.
//  Guarantees termination: unmapped slots and silent slaves produce an error response.
// PARAMETERS
//  NUM_SLV   4            number of slave ports (1..8)
//  DEC_LO    28           low bit of slot-select address field
//  DEC_HI    29           high bit of slot-select field; slot = m_adr_i[DEC_HI:DEC_LO]
//  TMO_CYC   255          cycles in REQ without slave ack/err before timeout (>=2)
//  TMO_DATA  32'hDEAD_BEEF read data returned on timeout or unmapped-slot error
// PORTS
//  wb_clk_i   in   1           Wishbone clock
//  wb_rst_i   in   1           synchronous reset, active high
//  m_cyc_i    in   1           master cycle
//  m_stb_i    in   1           master strobe
//  m_we_i     in   1           master write enable
//  m_adr_i    in   32          master byte address
//  m_dat_i    in   32          master write data
//  m_sel_i    in   4           master byte selects
//  m_dat_o    out  32          read data to master (valid with m_ack_o)
//  m_ack_o    out  1           transfer ack, one-cycle pulse
//  m_err_o    out  1           transfer error, one-cycle pulse
//  s_cyc_o    out  NUM_SLV     per-slave cycle (one-hot or zero)
//  s_stb_o    out  NUM_SLV     per-slave strobe (equal to s_cyc_o)
//  s_we_o     out  1           shared write enable
//  s_adr_o    out  32          shared address (latched master address)
//  s_dat_o    out  32          shared write data
//  s_sel_o    out  4           shared byte selects
//  s_dat_i    in   32*NUM_SLV  slave read data, slot k at [32k+31:32k]
//  s_ack_i    in   NUM_SLV     per-slave ack
//  s_err_i    in   NUM_SLV     per-slave error
//  tmo_flag_o out  1           sticky: any timeout since reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timer 0, tmo_flag_o 0; applies mid-transfer too.
//  - FSM IDLE/REQ/RESP, all outputs registered.
//  - IDLE: on m_cyc_i&m_stb_i latch adr/we/dat/sel and slot. slot<NUM_SLV -> REQ,
//    s_cyc_o/s_stb_o[slot]=1 from next cycle. slot>=NUM_SLV -> RESP with m_err_o=1,
//    m_dat_o=TMO_DATA; no slave strobed.
//  - REQ: sample only s_ack_i[slot]/s_err_i[slot]. On either: drop strobes, go RESP,
//    m_ack_o=ack&~err, m_err_o=err, m_dat_o=s_dat_i slice (TMO_DATA if err).
//    Both asserted -> error wins. Other slaves' ack/err ignored.
//  - Timer: clears on REQ entry, +1 per REQ cycle; at TMO_CYC-1 with no response:
//    drop strobes, RESP with m_err_o=1, m_dat_o=TMO_DATA, set tmo_flag_o.
//    Slave response on the same cycle as timeout wins (normal completion).
//  - Master abort: m_cyc_i low in REQ -> drop strobes, IDLE, no m_ack_o/m_err_o.
//  - RESP: ack/err high exactly one cycle, then IDLE; new request not accepted in
//    RESP (master drops stb after ack). Late ack from a timed-out slave is ignored.
//  - Latency: request accepted at edge N, slave strobe visible N+1; slave ack sampled
//    at edge M -> m_ack_o high in cycle after M. Minimum 3 cycles stb->ack.
//  - Unmapped error: m_err_o high 2 cycles after stb asserted.
//  - m_dat_o holds its value outside ack (not forced to 0); writes ignore read data.
// STRUCTURE
//  - wb_slv_decoder_pkg: state encoding localparams, TMO_DATA default, slot-width
//    function (clog2 of NUM_SLV).
//  - One natural sub-module: wb_tmo_timer (clear/enable/expire, width clog2(TMO_CYC+1)).
//  - Read-data mux indexed by latched slot; no combinational path master->slave.
// TESTING
//  - Read slot1 (adr 0x1000_0004), slave1 acks after 2 cycles, data 0x1234_5678 ->
//    s_stb_o=4'b0010, m_ack_o one cycle, m_dat_o=0x1234_5678, m_err_o=0.
//  - Write slot3 adr 0x3000_0010 dat 0xA5A5_0F0F sel 4'b0101 -> s_we_o=1, s_dat_o/sel
//    match, single ack pulse; other s_stb_o bits stay 0.
//  - NUM_SLV=3, access adr 0x3000_0000 -> no strobe, m_err_o after 2 cycles,
//    m_dat_o=0xDEAD_BEEF, tmo_flag_o stays 0.
//  - Slave0 never acks, TMO_CYC=16 -> strobe dropped after 16 cycles, m_err_o pulse,
//    tmo_flag_o=1 sticky; later slave0 ack ignored; next read slot2 completes normally.
//  - Slave2 asserts ack and err together -> m_err_o=1, m_ack_o=0.
//  - Reset asserted while in REQ / master drops m_cyc_i in REQ -> strobes 0 next cycle,
//    no ack/err pulse, subsequent transfer completes.

Source files
------------

// File: rtl/wb_slv_decoder_pkg.sv
// Shared types and helpers for the Wishbone slave decoder.
// Holds the FSM state encoding, the default error read data and the slot-width helper.
package wb_slv_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } dec_state_t;

    localparam logic [31:0] TMO_DATA_DEF = 32'hDEAD_BEEF;

    // Width of a latched slot index; never below one bit so a single-slave build still indexes.
    function automatic int slot_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wb_slv_decoder_tmo_timer.sv
// Response timeout timer for the decoder: counts cycles spent waiting on a slave.
// The count restarts on clear and flags expiry on the last permitted wait cycle.
module wb_tmo_timer #(
    parameter int TMO_CYC = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int TW = $clog2(TMO_CYC + 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign o_expire = i_en && (r_cnt == TW'(TMO_CYC - 1));

endmodule

// File: rtl/wb_slv_decoder.sv
// Single-master Wishbone classic decoder: routes one transfer at a time to the slave slot
// selected by address bits, and always terminates it (ack, slave error, unmapped or timeout).
//
// state   | meaning
// IDLE    | waiting for m_cyc_i & m_stb_i; request is latched here
// REQ     | one slave strobed, waiting for its ack/err, timeout or master abort
// RESP    | m_ack_o or m_err_o high for this single cycle
module wb_slv_decoder
    import wb_slv_decoder_pkg::*;
#(
    parameter int          NUM_SLV  = 4,
    parameter int          DEC_LO   = 28,
    parameter int          DEC_HI   = 29,
    parameter int          TMO_CYC  = 255,
    parameter logic [31:0] TMO_DATA = TMO_DATA_DEF
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  m_cyc_i,
    input  logic                  m_stb_i,
    input  logic                  m_we_i,
    input  logic [31:0]           m_adr_i,
    input  logic [31:0]           m_dat_i,
    input  logic [3:0]            m_sel_i,
    output logic [31:0]           m_dat_o,
    output logic                  m_ack_o,
    output logic                  m_err_o,
    output logic [NUM_SLV-1:0]    s_cyc_o,
    output logic [NUM_SLV-1:0]    s_stb_o,
    output logic                  s_we_o,
    output logic [31:0]           s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    input  logic [32*NUM_SLV-1:0] s_dat_i,
    input  logic [NUM_SLV-1:0]    s_ack_i,
    input  logic [NUM_SLV-1:0]    s_err_i,
    output logic                  tmo_flag_o
);

    localparam int          SLOT_W    = slot_width(NUM_SLV);
    localparam int          NPAD      = 1 << SLOT_W;
    localparam logic [31:0] NUM_SLV_U = NUM_SLV;

    dec_state_t          r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [NUM_SLV-1:0]  r_cyc;
    logic                r_we;
    logic [31:0]         r_adr;
    logic [31:0]         r_wdat;
    logic [3:0]          r_sel;
    logic [31:0]         r_rdat;
    logic                r_ack;
    logic                r_err;
    logic                r_tmo;

    logic                w_req;
    logic                w_map;
    logic [SLOT_W-1:0]   w_slot;
    logic [NPAD-1:0]     w_ack_vec;
    logic [NPAD-1:0]     w_err_vec;
    logic                w_ack;
    logic                w_err;
    logic [31:0]         w_sdat [NPAD];
    logic                w_tmo;

    assign w_req  = m_cyc_i && m_stb_i;
    assign w_map  = 32'(m_adr_i[DEC_HI:DEC_LO]) < NUM_SLV_U;
    assign w_slot = SLOT_W'(m_adr_i >> DEC_LO);

    // Padded to a power of two so the latched slot can index without range gaps.
    assign w_ack_vec = NPAD'(s_ack_i);
    assign w_err_vec = NPAD'(s_err_i);
    assign w_ack     = w_ack_vec[r_slot];
    assign w_err     = w_err_vec[r_slot];

    for (genvar k = 0; k < NPAD; k++) begin : g_rdat
        if (k < NUM_SLV) begin : g_used
            assign w_sdat[k] = s_dat_i[32*k +: 32];
        end else begin : g_pad
            assign w_sdat[k] = '0;
        end
    end

    wb_tmo_timer #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_clr    ((r_state == ST_IDLE) && w_req),
        .i_en     (r_state == ST_REQ),
        .o_expire (w_tmo)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
            r_cyc   <= '0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_rdat  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_slot <= w_slot;
                        r_we   <= m_we_i;
                        r_adr  <= m_adr_i;
                        r_wdat <= m_dat_i;
                        r_sel  <= m_sel_i;
                        if (w_map) begin
                            r_cyc   <= NUM_SLV'(1) << w_slot;
                            r_state <= ST_REQ;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdat  <= TMO_DATA;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_REQ: begin
                    if (!m_cyc_i) begin
                        r_cyc   <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_ack || w_err) begin
                        // A real slave response beats a timeout landing on the same cycle.
                        r_cyc   <= '0;
                        r_ack   <= w_ack && !w_err;
                        r_err   <= w_err;
                        if (w_err) begin
                            r_rdat <= TMO_DATA;
                        end else if (!r_we) begin
                            r_rdat <= w_sdat[r_slot];
                        end
                        r_state <= ST_RESP;
                    end else if (w_tmo) begin
                        r_cyc   <= '0;
                        r_err   <= 1'b1;
                        r_rdat  <= TMO_DATA;
                        r_tmo   <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_cyc   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_dat_o    = r_rdat;
    assign m_ack_o    = r_ack;
    assign m_err_o    = r_err;
    assign s_cyc_o    = r_cyc;
    assign s_stb_o    = r_cyc;
    assign s_we_o     = r_we;
    assign s_adr_o    = r_adr;
    assign s_dat_o    = r_wdat;
    assign s_sel_o    = r_sel;
    assign tmo_flag_o = r_tmo;

endmodule

// File: tb/tb_wb_slv_decoder.sv
// Bench for wb_slv_decoder: directed master transfers against a configurable slave model,
// with expected responses queued at issue time and compared when the master sees ack/err.
module tb_wb_slv_decoder;

    localparam int NS = 4;

    typedef struct {
        logic        ack;
        logic        err;
        logic        we;
        logic [31:0] dat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0]   m_adr = '0, m_wdat = '0;
    logic [3:0]    m_sel = '0;
    logic [31:0]   m_dat_o;
    logic          m_ack_o, m_err_o;
    logic [NS-1:0] s_cyc_o, s_stb_o;
    logic          s_we_o;
    logic [31:0]   s_adr_o, s_dat_o;
    logic [3:0]    s_sel_o;
    logic [NS-1:0] s_ack_i = '0, s_err_i = '0;
    logic [31:0]   rd [NS];
    logic          tmo_flag_o;

    int   dly [NS];
    logic ack_cfg [NS], err_cfg [NS], silent [NS], force_ack [NS];
    int   scnt [NS];

    exp_t        sb [$];
    int          checks = 0, failures = 0;
    logic [NS-1:0] stb_seen;
    int          stb_cnt;
    logic        cap_we;
    logic [31:0] cap_dat, cap_adr;
    logic [3:0]  cap_sel;
    logic        prev_resp = 1'b0;

    always #5 clk = ~clk;

    wb_slv_decoder #(
        .NUM_SLV (NS),
        .DEC_LO  (28),
        .DEC_HI  (30),
        .TMO_CYC (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .m_cyc_i    (m_cyc),
        .m_stb_i    (m_stb),
        .m_we_i     (m_we),
        .m_adr_i    (m_adr),
        .m_dat_i    (m_wdat),
        .m_sel_i    (m_sel),
        .m_dat_o    (m_dat_o),
        .m_ack_o    (m_ack_o),
        .m_err_o    (m_err_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_sel_o    (s_sel_o),
        .s_dat_i    ({rd[3], rd[2], rd[1], rd[0]}),
        .s_ack_i    (s_ack_i),
        .s_err_i    (s_err_i),
        .tmo_flag_o (tmo_flag_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Slave model: respond after dly[k] strobed cycles unless silent; force_ack drives ack while idle.
    always @(negedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (s_stb_o[k]) begin
                if (!silent[k] && scnt[k] == dly[k]) begin
                    s_ack_i[k] = ack_cfg[k];
                    s_err_i[k] = err_cfg[k];
                end else begin
                    s_ack_i[k] = 1'b0;
                    s_err_i[k] = 1'b0;
                end
                scnt[k]++;
            end else begin
                scnt[k]    = 0;
                s_ack_i[k] = force_ack[k];
                s_err_i[k] = 1'b0;
            end
        end
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) chk("cyc_eq_stb", 32'(s_cyc_o), 32'(s_stb_o));
        if (s_stb_o != '0) begin
            stb_seen |= s_stb_o;
            stb_cnt++;
            cap_we  = s_we_o;
            cap_dat = s_dat_o;
            cap_sel = s_sel_o;
            cap_adr = s_adr_o;
        end
        if (m_ack_o || m_err_o) begin
            chk("resp_one_cycle", 32'(prev_resp), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_resp", {30'd0, m_ack_o, m_err_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("m_ack", 32'(m_ack_o), 32'(e.ack));
                chk("m_err", 32'(m_err_o), 32'(e.err));
                if (!e.we || e.err) chk("m_dat", m_dat_o, e.dat);
            end
        end
        prev_resp = m_ack_o || m_err_o;
    end

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic eack, input logic eerr,
                        input logic [31:0] edat, output int lat);
        exp_t e;
        logic got;
        e.ack = eack; e.err = eerr; e.we = we; e.dat = edat;
        sb.push_back(e);
        @(posedge clk); #1;
        stb_seen = '0;
        stb_cnt  = 0;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we;
        m_adr = adr; m_wdat = dat; m_sel = sel;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (m_ack_o || m_err_o) got = 1'b1;
        end
        chk("xfer_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic start_req(input logic [31:0] adr);
        @(posedge clk); #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = adr; m_sel = 4'hF;
    endtask

    initial begin
        int lat;
        for (int k = 0; k < NS; k++) begin
            dly[k] = 0; ack_cfg[k] = 1'b1; err_cfg[k] = 1'b0;
            silent[k] = 1'b0; force_ack[k] = 1'b0; scnt[k] = 0;
        end
        rd[0] = 32'hC0C0_0000; rd[1] = 32'h1234_5678;
        rd[2] = 32'hCAFE_0002; rd[3] = 32'h3333_3333;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(m_ack_o), 32'd0);
        chk("rst_err", 32'(m_err_o), 32'd0);
        chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        chk("rst_adr", s_adr_o, 32'd0);
        chk("rst_tmo", 32'(tmo_flag_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Read slot1, ack after two wait cycles; slave3 ack noise must be ignored.
        dly[1] = 2; force_ack[3] = 1'b1;
        xfer(32'h1000_0004, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h1234_5678, lat);
        chk("rd1_stb", 32'(stb_seen), 32'b0010);
        chk("rd1_lat", lat, 5);
        chk("rd1_adr", cap_adr, 32'h1000_0004);
        chk("rd1_hold", m_dat_o, 32'h1234_5678);
        force_ack[3] = 1'b0;

        // Write slot3 with immediate ack: minimum latency.
        xfer(32'h3000_0010, 1'b1, 32'hA5A5_0F0F, 4'b0101, 1'b1, 1'b0, 32'h0, lat);
        chk("wr3_stb", 32'(stb_seen), 32'b1000);
        chk("wr3_we", 32'(cap_we), 32'd1);
        chk("wr3_dat", cap_dat, 32'hA5A5_0F0F);
        chk("wr3_sel", 32'(cap_sel), 32'b0101);
        chk("wr3_lat", lat, 3);

        // Unmapped slot (field value 4 with four slaves).
        xfer(32'h4000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, lat);
        chk("unm_stb", 32'(stb_seen), 32'd0);
        chk("unm_lat", lat, 2);
        chk("unm_tmo", 32'(tmo_flag_o), 32'd0);

        // Slave0 silent: timeout after 16 strobed cycles.
        silent[0] = 1'b1;
        xfer(32'h0000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, lat);
        chk("tmo_stb_cycles", stb_cnt, 16);
        chk("tmo_lat", lat, 18);
        chk("tmo_flag", 32'(tmo_flag_o), 32'd1);
        force_ack[0] = 1'b1;
        repeat (3) @(posedge clk);
        force_ack[0] = 1'b0;
        @(negedge clk);
        chk("late_ack_ign", {30'd0, m_ack_o, m_err_o}, 32'd0);
        silent[0] = 1'b0;

        // Normal read slot2 after the timeout; flag stays sticky.
        dly[2] = 1;
        xfer(32'h2000_0008, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_0002, lat);
        chk("rd2_stb", 32'(stb_seen), 32'b0100);
        chk("rd2_tmo_sticky", 32'(tmo_flag_o), 32'd1);

        // Slave2 asserts ack and err together: error wins.
        err_cfg[2] = 1'b1;
        xfer(32'h2000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, lat);
        err_cfg[2] = 1'b0;

        // Slave1 error without ack.
        ack_cfg[1] = 1'b0; err_cfg[1] = 1'b1; dly[1] = 0;
        xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF, lat);
        ack_cfg[1] = 1'b1; err_cfg[1] = 1'b0;

        // Ack on the very cycle the timer expires: normal completion.
        dly[0] = 15;
        xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hC0C0_0000, lat);
        chk("edge_lat", lat, 18);
        dly[0] = 0;

        // Master abort in REQ.
        silent[1] = 1'b1;
        start_req(32'h1000_0000);
        repeat (3) @(negedge clk);
        chk("abort_stb_before", 32'(s_stb_o), 32'b0010);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_stb_after", 32'(s_stb_o), 32'd0);
        repeat (3) @(posedge clk);
        silent[1] = 1'b0;
        xfer(32'h1000_0000, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h1234_5678, lat);
        chk("abort_next_stb", 32'(stb_seen), 32'b0010);

        // Reset while in REQ.
        silent[2] = 1'b1;
        start_req(32'h2000_0000);
        repeat (3) @(negedge clk);
        chk("rstreq_stb_before", 32'(s_stb_o), 32'b0100);
        @(posedge clk); #1;
        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstreq_stb_after", 32'(s_stb_o), 32'd0);
        chk("rstreq_tmo_clr", 32'(tmo_flag_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        silent[2] = 1'b0;
        xfer(32'h2000_0004, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 32'hCAFE_0002, lat);
        chk("rstreq_next_lat", lat, 4);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
